// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe: two-stage pipelined converter from the 24-bit GPU float
// format (sign[23], exp[22:15] bias 127, frac[14:0]) to a signed
// two's-complement integer of INT_W bits, with valid/ready on both sides
// and a sideband tag carried alongside every operand.
// Stage 1 classifies the operand; stage 2 shifts, rounds, negates and
// saturates, and its registers drive the outputs directly.
// Optional feature: define FP_TO_INT_RNE_EN to add the rne_i port, which
// selects round-to-nearest-even per operand instead of truncation.

module fp_to_int_pipe #(
  parameter int WIDTH = 24,
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [TAG_W-1:0] tag_i,
`ifdef FP_TO_INT_RNE_EN
  input  logic             rne_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [INT_W-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             overflow_o,
  output logic             inexact_o
);

  // Operand classes resolved in stage 1 so stage 2 only does arithmetic.
  typedef enum logic [2:0] {
    CLS_ZERO,  // |value| < 1 (or rounds to 0): result 0
    CLS_ONE,   // RNE only: 0.5 < |value| < 1 rounds to magnitude 1
    CLS_NORM,  // 0 <= E <= INT_W-2: shift and negate
    CLS_SAT,   // too large or Inf: saturate by sign, overflow
    CLS_MIN,   // exactly -2^(INT_W-1): representable, no overflow
    CLS_NAN    // NaN: result 0, overflow
  } cls_e;

  localparam logic [7:0]       EMAX    = 8'(INT_W - 1);
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  // Handshake: an empty stage never blocks the one upstream of it.
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, accept, s2_load;

  assign s2_adv  = !s2_valid_q || ready_i;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign ready_o = s1_adv;
  assign accept  = valid_i && s1_adv;
  assign s2_load = s2_adv && s1_valid_q;

  // Input field split. in_e is only meaningful when in_exp >= 127.
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [7:0]  in_e;
  logic [14:0] in_frac;
  logic [15:0] mag_d;
  logic        tiny_d;
  cls_e        cls_d;

  assign in_sign = a_i[WIDTH-1];
  assign in_exp  = a_i[WIDTH-2:WIDTH-9];
  assign in_frac = a_i[14:0];
  assign in_e    = in_exp - 8'd127;
  assign mag_d   = {1'b1, in_frac};
  assign tiny_d  = (in_exp != 8'd0) || (in_frac != '0);

  // Classify the incoming operand into one of the special-case classes.
  always_comb begin
    cls_d = CLS_ZERO;
    if (in_exp == 8'hFF) begin
      cls_d = (in_frac != '0) ? CLS_NAN : CLS_SAT;
    end else if (in_exp < 8'd127) begin
      cls_d = CLS_ZERO;
`ifdef FP_TO_INT_RNE_EN
      if (rne_i && (in_exp == 8'd126) && (in_frac != '0)) begin
        cls_d = CLS_ONE;
      end
`endif
    end else if (in_e >= EMAX) begin
      cls_d = ((in_e == EMAX) && (in_frac == '0) && in_sign) ? CLS_MIN : CLS_SAT;
    end else begin
      cls_d = CLS_NORM;
    end
  end

  // Stage 1 registers: sign, exponent (as a shift amount), mantissa, class, tag.
  logic             sign_q;
  logic [4:0]       e_q;
  logic [15:0]      mag_q;
  cls_e             cls_q;
  logic             tiny_q;
  logic [TAG_W-1:0] tag1_q;
`ifdef FP_TO_INT_RNE_EN
  logic             rne_q;
`endif

  // Stage 1 valid and data; flush wins over an accept in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      e_q        <= '0;
      mag_q      <= '0;
      cls_q      <= CLS_ZERO;
      tiny_q     <= 1'b0;
      tag1_q     <= '0;
`ifdef FP_TO_INT_RNE_EN
      rne_q      <= 1'b0;
`endif
    end else begin
      if (flush_i) begin
        s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
        s1_valid_q <= valid_i;
      end
      if (accept) begin
        sign_q <= in_sign;
        e_q    <= in_e[4:0];
        mag_q  <= mag_d;
        cls_q  <= cls_d;
        tiny_q <= tiny_d;
        tag1_q <= tag_i;
`ifdef FP_TO_INT_RNE_EN
        rne_q  <= rne_i;
`endif
      end
    end
  end

  // prod holds |value| as fixed point with 15 fraction bits: mag * 2^E.
  logic [45:0]      prod;
  logic             frac_nz;
  logic             round_up;
  logic [31:0]      mag_w;
  logic [INT_W-1:0] mag_int;
  logic             pos_ovf;
  logic             unused_bits;

  assign prod    = {30'b0, mag_q} << e_q;
  assign frac_nz = |prod[14:0];
`ifdef FP_TO_INT_RNE_EN
  assign round_up = rne_q && prod[14] && ((|prod[13:0]) || prod[15]);
`else
  assign round_up = 1'b0;
`endif
  assign mag_w       = {1'b0, prod[45:15]} + 32'(round_up);
  assign mag_int     = mag_w[INT_W-1:0];
  assign pos_ovf     = !sign_q && mag_w[INT_W-1];
  assign unused_bits = ^mag_w;

  logic [INT_W-1:0] res_d;
  logic             ovf_d;
  logic             inex_d;

  // Stage 2 arithmetic: pick the result and flags for the stage-1 class.
  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    inex_d = 1'b0;
    case (cls_q)
      CLS_ZERO: begin
        inex_d = tiny_q;
      end
      CLS_ONE: begin
        res_d  = sign_q ? {INT_W{1'b1}} : {{(INT_W-1){1'b0}}, 1'b1};
        inex_d = tiny_q;
      end
      CLS_NORM: begin
        inex_d = frac_nz;
        if (pos_ovf) begin
          res_d = INT_MAX;
          ovf_d = 1'b1;
        end else begin
          res_d = sign_q ? (~mag_int + {{(INT_W-1){1'b0}}, 1'b1}) : mag_int;
        end
      end
      CLS_SAT: begin
        res_d = sign_q ? INT_MIN : INT_MAX;
        ovf_d = 1'b1;
      end
      CLS_MIN: begin
        res_d = INT_MIN;
      end
      CLS_NAN: begin
        ovf_d = 1'b1;
      end
      default: begin
        res_d = '0;
      end
    endcase
  end

  logic [INT_W-1:0] result_q;
  logic [TAG_W-1:0] tag2_q;
  logic             ovf_q;
  logic             inex_q;

  // Stage 2 valid and output registers; data holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      tag2_q     <= '0;
      ovf_q      <= 1'b0;
      inex_q     <= 1'b0;
    end else begin
      if (flush_i) begin
        s2_valid_q <= 1'b0;
      end else if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        result_q <= res_d;
        tag2_q   <= tag1_q;
        ovf_q    <= ovf_d;
        inex_q   <= inex_d;
      end
    end
  end

  assign valid_o    = s2_valid_q;
  assign result_o   = result_q;
  assign tag_o      = tag2_q;
  assign overflow_o = ovf_q;
  assign inexact_o  = inex_q;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// tb_fp_to_int_pipe: self-checking bench for fp_to_int_pipe. Directed
// vectors use hand-derived constants; random traffic is scored against a
// real-arithmetic reference model and a queue of expected results.

module tb_fp_to_int_pipe;

  localparam int INT_W = 32;
  localparam int TAG_W = 4;
`ifdef FP_TO_INT_RNE_EN
  localparam bit HAS_RNE = 1'b1;
`else
  localparam bit HAS_RNE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [23:0]      a_i;
  logic [TAG_W-1:0] tag_i;
  logic             rne_i;
  logic             valid_o;
  logic             ready_i;
  logic [INT_W-1:0] result_o;
  logic [TAG_W-1:0] tag_o;
  logic             overflow_o;
  logic             inexact_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inex;
    logic [3:0]  tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  fp_to_int_pipe #(.WIDTH(24), .INT_W(INT_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .tag_i     (tag_i),
`ifdef FP_TO_INT_RNE_EN
    .rne_i     (rne_i),
`endif
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .tag_o     (tag_o),
    .overflow_o(overflow_o),
    .inexact_o (inexact_o)
  );

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) begin
      for (int i = 0; i < e; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -e; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Reference: evaluate the float as a real number, then truncate or round.
  function automatic exp_t model(input logic [23:0] a, input logic [3:0] t, input bit rn);
    exp_t   r;
    real    v, lim, fl, fr;
    longint li;
    bit     sgn;
    int     ex, fb;
    sgn    = a[23];
    ex     = int'(a[22:15]);
    fb     = int'(a[14:0]);
    r.res  = 32'h0;
    r.ovf  = 1'b0;
    r.inex = 1'b0;
    r.tag  = t;
    lim    = pow2(INT_W - 1);
    if (ex == 255) begin
      r.ovf = 1'b1;
      if (fb == 0) r.res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    if (ex == 0 && fb == 0) return r;
    v = (1.0 + real'(fb) / 32768.0) * pow2(ex - 127);
    if (v > lim || (v == lim && !sgn)) begin
      r.ovf = 1'b1;
      r.res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    if (v == lim) begin
      r.res = 32'h8000_0000;
      return r;
    end
    fl     = $floor(v);
    fr     = v - fl;
    r.inex = (fr != 0.0);
    li     = longint'(fl);
    if (rn && (fr > 0.5 || (fr == 0.5 && li[0]))) li = li + 1;
    if (!sgn && real'(li) >= lim) begin
      r.ovf = 1'b1;
      r.res = 32'h7FFF_FFFF;
      return r;
    end
    r.res = sgn ? 32'(-li) : 32'(li);
    return r;
  endfunction

  // Operand mix biased toward interesting exponents and special values.
  function automatic logic [23:0] rand_operand();
    logic        s;
    logic [7:0]  e;
    logic [14:0] f;
    s = 1'($urandom_range(0, 1));
    f = 15'($urandom);
    if ($urandom_range(0, 4) == 0) f = '0;
    case ($urandom_range(0, 9))
      0:       e = 8'hFF;
      1:       e = 8'($urandom_range(0, 126));
      2:       e = 8'($urandom_range(157, 170));
      3:       e = 8'd126;
      default: e = 8'($urandom_range(127, 156));
    endcase
    return {s, e, f};
  endfunction

  task automatic drive(input bit v, input logic [23:0] a, input logic [3:0] t,
                       input bit rdy, input bit fl, input bit rn);
    @(negedge clk);
    valid_i = v;
    a_i     = a;
    tag_i   = t;
    ready_i = rdy;
    flush_i = fl;
    rne_i   = rn;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h expected 0", result_o); end
    checks++; if (tag_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_tag got %h expected 0", tag_o); end
    checks++; if ({overflow_o, inexact_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b expected 00", {overflow_o, inexact_o}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", ready_o); end
  endtask

  task automatic test_directed();
    logic [23:0] va [10] = '{24'h3F8000, 24'h402000, 24'hC02000, 24'h4F0000, 24'hCF0000,
                             24'h7F8000, 24'h7F8001, 24'h3F4000, 24'hBF4000, 24'h000000};
    logic [31:0] vr [10] = '{32'h1, 32'h2, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    bit vo [10] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
    bit vi [10] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    logic [23:0] a;
    for (int i = 0; i < 12; i++) begin
      a = '0;
      if (i < 10) a = va[i];
      drive(i < 10, a, 4'(i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (i < 2) begin
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL dir_latency cycle %0d got valid %b expected 0", i, valid_o); end
      end else if (valid_o !== 1'b1 || result_o !== vr[i-2] || overflow_o !== vo[i-2] ||
                   inexact_o !== vi[i-2] || tag_o !== 4'(i-2)) begin
        errors++;
        $display("[TB] FAIL dir_vec a=%h got v=%b r=%h o=%b x=%b t=%h expected v=1 r=%h o=%b x=%b t=%h",
                 va[i-2], valid_o, result_o, overflow_o, inexact_o, tag_o, vr[i-2], vo[i-2], vi[i-2], 4'(i-2));
      end
    end
  endtask

  task automatic test_stall();
    int             sent, got;
    bit             rdy;
    logic [23:0]    a;
    logic [38:0]    snap;
    exp_t           e;
    sent = 0;
    got  = 0;
    snap = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      rdy = !(c >= 3 && c <= 5);
      a   = rand_operand();
      drive(sent < 5, a, 4'(sent), rdy, 1'b0, 1'b0);
      if (!rdy) begin
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
          errors++; $display("[TB] FAIL stall_ready cycle %0d got ready_o=%b valid_o=%b expected 0 1", c, ready_o, valid_o);
        end
        if (c == 3) snap = {result_o, tag_o, overflow_o, inexact_o};
        else begin
          checks++;
          if ({result_o, tag_o, overflow_o, inexact_o} !== snap) begin
            errors++; $display("[TB] FAIL stall_hold got %h expected %h", {result_o, tag_o, overflow_o, inexact_o}, snap);
          end
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        got++;
        if (sbq.size() == 0) begin
          errors++; $display("[TB] FAIL stall_extra got tag %h expected none", tag_o);
        end else begin
          e = sbq.pop_front();
          if ({result_o, overflow_o, inexact_o, tag_o} !== {e.res, e.ovf, e.inex, e.tag}) begin
            errors++; $display("[TB] FAIL stall_data got r=%h o=%b x=%b t=%h expected r=%h o=%b x=%b t=%h",
                               result_o, overflow_o, inexact_o, tag_o, e.res, e.ovf, e.inex, e.tag);
          end
        end
      end
      if (valid_i && ready_o) begin
        sbq.push_back(model(a, 4'(sent), 1'b0));
        sent++;
      end
    end
    checks++;
    if (got != 5 || sbq.size() != 0) begin
      errors++; $display("[TB] FAIL stall_count got %0d outputs expected 5 (pending %0d)", got, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_flush();
    exp_t e;
    drive(1'b1, 24'h3F8000, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 24'h402000, 4'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 24'hC02000, 4'd3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_full got ready_o=%b valid_o=%b expected 0 1", ready_o, valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop cycle %0d got valid %b expected 0", i, valid_o); end
    end
    drive(1'b1, 24'h40A000, 4'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b expected 1", ready_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_accept cycle %0d got valid %b expected 0", i, valid_o); end
    end
    e = model(24'h412000, 4'd6, 1'b0);
    drive(1'b1, 24'h412000, 4'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_fresh_early got valid %b expected 0", valid_o); end
    drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || {result_o, overflow_o, inexact_o, tag_o} !== {e.res, e.ovf, e.inex, e.tag}) begin
      errors++; $display("[TB] FAIL flush_fresh got v=%b r=%h t=%h expected v=1 r=%h t=%h", valid_o, result_o, tag_o, e.res, e.tag);
    end
    drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 24'h3F8000, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 24'h402000, 4'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 24'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_fill got valid %b expected 1", valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || result_o !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_clear got v=%b r=%h expected v=0 r=0", valid_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 24'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drop cycle %0d got valid %b expected 0", i, valid_o); end
    end
    sbq.delete();
  endtask

  task automatic test_random();
    bit          v, rdy, fl, rn, hold;
    logic [23:0] a;
    logic [3:0]  t;
    logic [38:0] prev;
    exp_t        e;
    hold = 1'b0;
    prev = '0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 49) == 0);
      end else begin
        v   = 1'b0;
        rdy = 1'b1;
        fl  = 1'b0;
      end
      rn = HAS_RNE && ($urandom_range(0, 1) == 1);
      a  = rand_operand();
      t  = 4'($urandom);
      drive(v, a, t, rdy, fl, rn);
      if (hold) begin
        checks++;
        if (valid_o !== 1'b1 || {result_o, tag_o, overflow_o, inexact_o} !== prev) begin
          errors++; $display("[TB] FAIL rand_hold got v=%b %h expected v=1 %h", valid_o, {result_o, tag_o, overflow_o, inexact_o}, prev);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra got tag %h expected none", tag_o);
        end else begin
          e = sbq.pop_front();
          if ({result_o, overflow_o, inexact_o, tag_o} !== {e.res, e.ovf, e.inex, e.tag}) begin
            errors++; $display("[TB] FAIL rand_data got r=%h o=%b x=%b t=%h expected r=%h o=%b x=%b t=%h",
                               result_o, overflow_o, inexact_o, tag_o, e.res, e.ovf, e.inex, e.tag);
          end
        end
      end
      hold = valid_o && !ready_i && !flush_i;
      prev = {result_o, tag_o, overflow_o, inexact_o};
      if (flush_i) sbq.delete();
      else if (valid_i && ready_o) sbq.push_back(model(a, t, rn));
    end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("[TB] FAIL rand_drain got %0d pending expected 0", sbq.size()); end
    sbq.delete();
  endtask

`ifdef FP_TO_INT_RNE_EN
  task automatic test_rne();
    logic [23:0] va [4] = '{24'h402000, 24'h406000, 24'h3F0000, 24'hBF4000};
    logic [31:0] vr [4] = '{32'h2, 32'h4, 32'h0, 32'hFFFF_FFFF};
    logic [23:0] a;
    for (int i = 0; i < 6; i++) begin
      a = '0;
      if (i < 4) a = va[i];
      drive(i < 4, a, 4'(i), 1'b1, 1'b0, 1'b1);
      if (i >= 2) begin
        checks++;
        if (valid_o !== 1'b1 || result_o !== vr[i-2] || overflow_o !== 1'b0 || tag_o !== 4'(i-2)) begin
          errors++; $display("[TB] FAIL rne_vec a=%h got v=%b r=%h o=%b expected v=1 r=%h o=0", va[i-2], valid_o, result_o, overflow_o, vr[i-2]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i     = '0;
    tag_i   = '0;
    rne_i   = 1'b0;
    $display("[TB] starting fp_to_int_pipe bench");
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_midflight();
    test_random();
`ifdef FP_TO_INT_RNE_EN
    test_rne();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_to_int_pipe.md
Name: fp_to_int_pipe

Overview:
- Two-stage pipelined converter from the 24-bit GPU float format (sign[23], exp[22:15] bias 127, frac[14:0]) to a signed two's-complement integer.
- Sits directly downstream of the floor unit: consumes floor/trunc results and produces integer texel coordinates and indices for the address path.
- Uses a valid/ready handshake on both sides, accepts one operand per cycle, and carries a sideband tag alongside each operand.

Parameters:
- WIDTH, 24, float operand width; format fixed at 1/8/15.
- INT_W, 32, output integer width; legal range 17..32.
- TAG_W, 4, sideband tag width, passed through unchanged.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush_i  input  1  synchronous; kills all in-flight entries
- valid_i  input  1  operand valid
- ready_o  output  1  converter can accept an operand this cycle
- a_i  input  WIDTH  float operand
- tag_i  input  TAG_W  sideband tag
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts the result
- result_o  output  INT_W  converted integer
- tag_o  output  TAG_W  tag of the result
- overflow_o  output  1  saturation occurred, or input was NaN/Inf
- inexact_o  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset (asynchronous): both stage valids are 0. valid_o=0, result_o=0, tag_o=0, overflow_o=0, inexact_o=0. ready_o=1 once rst deasserts.
- Decode:
  - E = exp-127, signed 9 bits. mag = {1,frac}, 16 bits.
  - If E<=15: int = mag>>(15-E). Otherwise: int = mag<<(E-15).
  - Negate when sign=1.
- Rounding: truncate toward zero. inexact = any mag bits shifted out, or (exp<127 and (exp!=0 or frac!=0)).
- Special cases:
  - exp<127 (includes zero and denormals): result 0. Negative values also give 0, never -0 or -1.
  - E>=INT_W-1: saturate to INT_MAX (sign=0) or INT_MIN (sign=1), overflow=1.
  - Exception: E==INT_W-1, frac==0, sign=1 gives exactly INT_MIN with overflow=0.
  - exp==255 with frac==0 (Inf): saturate by sign, overflow=1.
  - exp==255 with frac!=0 (NaN): result 0, overflow=1.
- Pipeline:
  - S1 registers sign, E, mag, the special-case class and the tag.
  - S2 registers the shifted, negated, saturated result and the flags. S2 drives the outputs.
  - Latency is 2 cycles from input handshake to valid_o when no stall occurs. Throughput is 1 per cycle.
- Handshake:
  - Transfer happens when valid and ready are both high.
  - s2_adv = !s2_valid | ready_i. s1_adv = !s1_valid | s2_adv. ready_o = s1_adv, which is purely combinational from state and ready_i.
  - While valid_o=1 and ready_i=0: result_o, tag_o and flags hold stable; valid_o stays 1.
  - A stage whose valid is 0 never blocks an upstream stage (bubble collapse).
- Flush: flush_i=1 clears both valids on the next edge and takes precedence over an accept in the same cycle (the operand is dropped). ready_o is unaffected. Data registers need not clear.
- Output data registers load only on an S2 advance with S1 valid; they hold otherwise. Flags are meaningful only while valid_o=1.
- Reset during operation drops all in-flight operands; no partial result is emitted.

Optional Feature:
- Macro FP_TO_INT_RNE_EN.
- When defined:
  - Adds input port rne_i (1 bit), sampled with the operand and carried in S1.
  - rne_i=1 selects round-to-nearest-even instead of truncation. Rounding applies to |value| before negation.
  - exp<126 gives 0. exp==126 gives 0 when frac==0 (exactly 0.5), else ±1.
  - A round-up that reaches 2^(INT_W-1) for positive values saturates and sets overflow.
- When undefined: no rne_i port; truncation only.

Test Plan:
- a_i=0x3F8000 (1.0), 0x402000 (2.5), 0xC02000 (-2.5) back-to-back, ready_i=1 -> results 1, 2, 0xFFFFFFFE on consecutive cycles starting 2 cycles after the first accept; inexact 0,1,1.
- a_i=0x4F0000 (2^31) -> 0x7FFFFFFF, overflow=1. a_i=0xCF0000 (-2^31) -> 0x80000000, overflow=0. a_i=0x7F8000 (+Inf) -> 0x7FFFFFFF, overflow=1. a_i=0x7F8001 (NaN) -> 0, overflow=1.
- a_i=0x3F4000 (0.75) and 0xBF4000 (-0.75) -> 0, inexact=1. a_i=0x000000 -> 0, inexact=0.
- Stream 5 operands with tags 0..4 while ready_i is held 0 for 3 cycles mid-stream -> ready_o falls after both stages fill, nothing is lost or duplicated, and tags emerge in order 0..4 with held outputs stable during the stall.
- flush_i asserted with both stages full and valid_i=1 -> next cycle valid_o=0, and the flushed operands never appear; a fresh operand afterwards emerges at latency 2.
- FP_TO_INT_RNE_EN with rne_i=1: 0x402000 (2.5) -> 2, 0x406000 (3.5) -> 4, 0x3F0000 (0.5) -> 0, 0xBF4000 (-0.75) -> 0xFFFFFFFF.
